// File: rtl/mac_pipelined_param.sv
// Parametrised two-stage multiply-accumulate with clear, sign mode, saturation, sticky overflow and sample count.
// Latency: product registered on the sampling edge, accumulator updated on the following edge.
// Backpressure: none; accepts one sample per clock whenever in_valid is high, bubbles leave state untouched.
//
// Ports:
//   clk, reset        : single clock, synchronous active-high reset
//   in_valid, clear   : sample qualifier; clear starts a new sum with this sample's product
//   a, b              : WIDTH-bit operands (unsigned or two's complement per SIGNED)
//   acc_out, out_valid: ACC_WIDTH-bit running sum and its update strobe
//   overflow, count   : sticky overflow since last clear; saturating sample counter
module mac_pipelined_param #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 36,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 out_valid,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int  PW        = 2 * WIDTH;
  localparam bit  IS_SIGNED = (SIGNED != 0);
  localparam bit  IS_SAT    = (SATURATE != 0);

  // stage 1 state
  logic            v1;
  logic            c1;
  logic [PW-1:0]   p1;

  // stage 2 state
  logic [ACC_WIDTH-1:0] acc;

  // combinational datapath
  logic [PW-1:0]        a_x;
  logic [PW-1:0]        b_x;
  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 ovf;
  logic [ACC_WIDTH-1:0] sat_val;
  logic [ACC_WIDTH-1:0] acc_nxt;

  // Extending both operands to 2*WIDTH first makes the low 2*WIDTH bits of a
  // plain multiply correct for both signed and unsigned interpretation.
  always_comb begin
    a_x  = {{WIDTH{IS_SIGNED && a[WIDTH-1]}}, a};
    b_x  = {{WIDTH{IS_SIGNED && b[WIDTH-1]}}, b};
    prod = a_x * b_x;
  end

  always_comb begin
    ext          = {ACC_WIDTH{IS_SIGNED && p1[PW-1]}};
    ext[PW-1:0]  = p1;

    // One guard bit: carry-out for unsigned, duplicated sign for signed.
    sum = {IS_SIGNED && acc[ACC_WIDTH-1], acc} + {IS_SIGNED && ext[ACC_WIDTH-1], ext};

    sat_val = '1;
    ovf     = 1'b0;
    if (IS_SIGNED) begin
      // Guard and MSB disagree only when the true result left the signed range;
      // the guard bit then carries the true sign, selecting min vs max.
      ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
      sat_val = {ACC_WIDTH{~sum[ACC_WIDTH]}};
      sat_val[ACC_WIDTH-1] = sum[ACC_WIDTH];
    end else begin
      ovf = sum[ACC_WIDTH];
    end

    acc_nxt = (ovf && IS_SAT) ? sat_val : sum[ACC_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      c1        <= 1'b0;
      p1        <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      count     <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        p1 <= prod;
        c1 <= clear;
      end

      out_valid <= v1;
      if (v1) begin
        if (c1) begin
          // A product always fits ACC_WIDTH, so a clear never flags overflow.
          acc      <= ext;
          overflow <= 1'b0;
          count    <= CNT_WIDTH'(1);
        end else begin
          acc <= acc_nxt;
          if (ovf) begin
            overflow <= 1'b1;
          end
          if (count != '1) begin
            count <= count + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  assign acc_out = acc;

endmodule

// File: tb/tb_mac_pipelined_param.sv
module tb_mac_pipelined_param;

  logic clk;
  logic reset;

  logic        iv [4];
  logic        cl [4];
  logic [15:0] av [4];
  logic [15:0] bv [4];

  logic [35:0] acc0;
  logic [31:0] acc1, acc2, acc3;
  logic        vld0, vld1, vld2, vld3;
  logic        ovf0, ovf1, ovf2, ovf3;
  logic [7:0]  cnt0, cnt1, cnt2;
  logic [1:0]  cnt3;

  int checks = 0;
  int errors = 0;

  // u0: defaults (unsigned, 36-bit, saturating)
  mac_pipelined_param u0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .clear(cl[0]), .a(av[0]), .b(bv[0]),
    .acc_out(acc0), .out_valid(vld0), .overflow(ovf0), .count(cnt0));

  // u1: unsigned, 32-bit, saturating
  mac_pipelined_param #(.ACC_WIDTH(32)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .clear(cl[1]), .a(av[1]), .b(bv[1]),
    .acc_out(acc1), .out_valid(vld1), .overflow(ovf1), .count(cnt1));

  // u2: signed, 32-bit, saturating
  mac_pipelined_param #(.ACC_WIDTH(32), .SIGNED(1)) u2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .clear(cl[2]), .a(av[2]), .b(bv[2]),
    .acc_out(acc2), .out_valid(vld2), .overflow(ovf2), .count(cnt2));

  // u3: unsigned, 32-bit, wrapping, 2-bit counter
  mac_pipelined_param #(.ACC_WIDTH(32), .SATURATE(0), .CNT_WIDTH(2)) u3 (
    .clk(clk), .reset(reset), .in_valid(iv[3]), .clear(cl[3]), .a(av[3]), .b(bv[3]),
    .acc_out(acc3), .out_valid(vld3), .overflow(ovf3), .count(cnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int idx, input logic [15:0] x, input logic [15:0] y, input logic c);
    iv[idx] = 1'b1;
    av[idx] = x;
    bv[idx] = y;
    cl[idx] = c;
  endtask

  task automatic idle(input int idx);
    iv[idx] = 1'b0;
    cl[idx] = 1'b0;
  endtask

  // One sample followed by a bubble; result is visible on return.
  task automatic step(input int idx, input logic [15:0] x, input logic [15:0] y, input logic c);
    send(idx, x, y, c);
    tick();
    idle(idx);
    tick();
  endtask

  logic [15:0] s1_a [3] = '{16'd1, 16'd5, 16'd15};
  logic [15:0] s1_b [3] = '{16'd2, 16'd2, 16'd10};
  int          s1_exp [9] = '{2, 12, 162, 164, 174, 324, 326, 336, 486};

  initial begin
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0; cl[i] = 1'b0; av[i] = '0; bv[i] = '0;
    end
    reset = 1'b1;
    tick();
    tick();

    chk("rst_acc", 64'(acc0), 64'd0);
    chk("rst_vld", 64'(vld0), 64'd0);
    chk("rst_ovf", 64'(ovf0), 64'd0);
    chk("rst_cnt", 64'(cnt0), 64'd0);
    reset = 1'b0;

    // Scenario 1: back-to-back unsigned accumulation
    for (int i = 0; i < 10; i++) begin
      if (i < 9) send(0, s1_a[i % 3], s1_b[i % 3], i == 0);
      else       idle(0);
      tick();
      if (i > 0) begin
        chk("s1_acc", 64'(acc0), 64'(s1_exp[i-1]));
        chk("s1_vld", 64'(vld0), 64'd1);
      end
    end
    chk("s1_cnt", 64'(cnt0), 64'd9);
    chk("s1_ovf", 64'(ovf0), 64'd0);

    // Scenario 2: bubbles hold the sum, then a clear restarts it
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s2_hold_acc", 64'(acc0), 64'd486);
      chk("s2_hold_vld", 64'(vld0), 64'd0);
    end
    step(0, 16'd3, 16'd4, 1'b1);
    chk("s2_acc", 64'(acc0), 64'd12);
    chk("s2_cnt", 64'(cnt0), 64'd1);
    chk("s2_vld", 64'(vld0), 64'd1);

    // Scenario 3: unsigned saturation
    step(1, 16'hFFFF, 16'hFFFF, 1'b0);
    chk("s3_acc1", 64'(acc1), 64'hFFFE0001);
    chk("s3_ovf1", 64'(ovf1), 64'd0);
    step(1, 16'hFFFF, 16'hFFFF, 1'b0);
    chk("s3_acc2", 64'(acc1), 64'hFFFFFFFF);
    chk("s3_ovf2", 64'(ovf1), 64'd1);
    step(1, 16'hFFFF, 16'hFFFF, 1'b0);
    chk("s3_acc3", 64'(acc1), 64'hFFFFFFFF);
    chk("s3_ovf3", 64'(ovf1), 64'd1);
    chk("s3_cnt3", 64'(cnt1), 64'd3);
    step(1, 16'd1, 16'd1, 1'b1);
    chk("s3_clr_acc", 64'(acc1), 64'd1);
    chk("s3_clr_ovf", 64'(ovf1), 64'd0);
    chk("s3_clr_cnt", 64'(cnt1), 64'd1);

    // Scenario 4: signed mode
    step(2, 16'hFFFD, 16'd4, 1'b1);
    chk("s4_acc_m12", 64'(acc2), 64'hFFFFFFF4);
    step(2, 16'd2, 16'hFFFB, 1'b0);
    chk("s4_acc_m22", 64'(acc2), 64'hFFFFFFEA);
    step(2, 16'd7, 16'd7, 1'b0);
    chk("s4_acc_27", 64'(acc2), 64'd27);
    chk("s4_ovf", 64'(ovf2), 64'd0);
    step(2, 16'h8000, 16'h8000, 1'b1);
    chk("s4_big1", 64'(acc2), 64'h40000000);
    step(2, 16'h8000, 16'h8000, 1'b0);
    chk("s4_satmax", 64'(acc2), 64'h7FFFFFFF);
    chk("s4_satmax_ovf", 64'(ovf2), 64'd1);
    step(2, 16'hFFFF, 16'd1, 1'b0);
    chk("s4_sticky_acc", 64'(acc2), 64'h7FFFFFFE);
    chk("s4_sticky_ovf", 64'(ovf2), 64'd1);
    step(2, 16'h8000, 16'h7FFF, 1'b1);
    chk("s4_neg1", 64'(acc2), 64'hC0008000);
    chk("s4_neg1_ovf", 64'(ovf2), 64'd0);
    step(2, 16'h8000, 16'h7FFF, 1'b0);
    chk("s4_neg2", 64'(acc2), 64'h80010000);
    step(2, 16'h8000, 16'h7FFF, 1'b0);
    chk("s4_satmin", 64'(acc2), 64'h80000000);
    chk("s4_satmin_ovf", 64'(ovf2), 64'd1);

    // Scenario 5: wrap mode, ignored clear, counter saturation
    step(3, 16'hFFFF, 16'hFFFF, 1'b0);
    chk("s5_acc1", 64'(acc3), 64'hFFFE0001);
    chk("s5_ovf1", 64'(ovf3), 64'd0);
    step(3, 16'hFFFF, 16'hFFFF, 1'b0);
    chk("s5_wrap", 64'(acc3), 64'hFFFC0002);
    chk("s5_ovf2", 64'(ovf3), 64'd1);
    cl[3] = 1'b1;
    tick();
    cl[3] = 1'b0;
    tick();
    step(3, 16'd1, 16'd1, 1'b0);
    chk("s5_noclr_acc", 64'(acc3), 64'hFFFC0003);
    chk("s5_noclr_ovf", 64'(ovf3), 64'd1);
    chk("s5_cnt3", 64'(cnt3), 64'd3);
    step(3, 16'd0, 16'd0, 1'b0);
    chk("s5_cnt_hold", 64'(cnt3), 64'd3);

    // Scenario 6: reset with samples in flight
    send(0, 16'd10, 16'd10, 1'b0);
    tick();
    send(0, 16'd20, 16'd20, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(0);
    chk("s6_acc", 64'(acc0), 64'd0);
    chk("s6_vld", 64'(vld0), 64'd0);
    chk("s6_ovf", 64'(ovf0), 64'd0);
    chk("s6_cnt", 64'(cnt0), 64'd0);
    tick();
    chk("s6_flush_acc", 64'(acc0), 64'd0);
    chk("s6_flush_vld", 64'(vld0), 64'd0);
    step(0, 16'd2, 16'd3, 1'b0);
    chk("s6_acc6", 64'(acc0), 64'd6);
    chk("s6_cnt1", 64'(cnt0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
